// File: rtl/hall_sector_tracker_if.sv
// Hall tracker port bundle: raw hall lines in, accepted code / interpolated angle / status out.
// Master is the sensor side (drives the lines), slave is the tracker.
interface hall_sector_tracker_if;
   logic        hall_a;
   logic        hall_b;
   logic        hall_c;
   logic [31:0] hall_code;
   logic [31:0] hall_angle;
   logic        hall_valid;
   logic        edge_pulse;
   logic        hall_err;
   logic        dir;
   logic [23:0] period;
   logic        stall;

   modport master (
      output hall_a, hall_b, hall_c,
      input  hall_code, hall_angle, hall_valid, edge_pulse, hall_err, dir, period, stall
   );

   modport slave (
      input  hall_a, hall_b, hall_c,
      output hall_code, hall_angle, hall_valid, edge_pulse, hall_err, dir, period, stall
   );
endinterface

// File: rtl/hall_sector_tracker.sv
// Hall sector tracker: sync + glitch filter, direction, sector period, interpolated angle.
// Latency: 2 sync + FILT_LEN filter cycles to accept a code; step update 34 clk after an edge; no backpressure.
module hall_sector_tracker #(
   parameter int unsigned FILT_LEN   = 16,
   parameter logic [23:0] PERIOD_MAX = 24'hFFFFFF,
   parameter int unsigned FRAC       = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   hall_sector_tracker_if.slave  bus
);
   localparam int unsigned    FW       = $clog2(FILT_LEN + 1);
   localparam int unsigned    PW       = 20 + FRAC;
   localparam logic [22:0]    FULL     = 23'd3600000;
   localparam logic [32:0]    POS_MAX  = 33'(64'd599999 << FRAC);
   localparam logic [PW-1:0]  POS_MID  = PW'(64'd300000 << FRAC);
   localparam logic [31:0]    DIVIDEND = 32'(64'd600000 << FRAC);

   typedef enum logic [1:0] {D_IDLE, D_RUN, D_LOAD} div_state_t;

   logic [2:0]    sync1, sync2, code_q, code_r;
   logic [FW-1:0] fcnt;
   logic          stable_hit, is_inv, accept, fwd, rev;
   logic [2:0]    new_idx, old_idx;
   logic [21:0]   base;
   logic [PW-1:0] pos, pos_fwd, pos_rev;
   logic [32:0]   fsum;
   logic [22:0]   angle_sum, angle_mod;
   logic [31:0]   step;
   logic          valid_r, edge_r, err_r, dir_r, stall_r, period_ok;
   logic [23:0]   pcnt, pcnt_inc, period_r;
   div_state_t    div_st;
   logic [4:0]    div_cnt;
   logic [31:0]   div_q;
   logic [23:0]   div_rem, div_d;
   logic [24:0]   div_shift;

   // Sector index in ascending-angle order; lower bound is 300000 + idx*600000.
   function automatic logic [2:0] sec_idx(input logic [2:0] c);
      case (c)
         3'd5:    sec_idx = 3'd0;
         3'd1:    sec_idx = 3'd1;
         3'd3:    sec_idx = 3'd2;
         3'd2:    sec_idx = 3'd3;
         3'd6:    sec_idx = 3'd4;
         3'd4:    sec_idx = 3'd5;
         default: sec_idx = 3'd0;
      endcase
   endfunction

   always_comb begin
      stable_hit = (sync2 == code_q) && (fcnt == FW'(FILT_LEN - 1));
      is_inv     = (sync2 == 3'd0) || (sync2 == 3'd7);
      accept     = stable_hit && !is_inv && (sync2 != code_r);
      new_idx    = sec_idx(sync2);
      old_idx    = sec_idx(code_r);
      fwd        = valid_r && (new_idx == ((old_idx == 3'd5) ? 3'd0 : old_idx + 3'd1));
      rev        = valid_r && (old_idx == ((new_idx == 3'd5) ? 3'd0 : new_idx + 3'd1));
      pcnt_inc   = (pcnt == PERIOD_MAX) ? pcnt : pcnt + 24'd1;
      fsum       = 33'(pos) + 33'(step);
      pos_fwd    = (fsum > POS_MAX) ? POS_MAX[PW-1:0] : fsum[PW-1:0];
      pos_rev    = (33'(step) > 33'(pos)) ? '0 : pos - step[PW-1:0];
      angle_sum  = 23'(base) + 23'(pos >> FRAC);
      angle_mod  = (angle_sum >= FULL) ? angle_sum - FULL : angle_sum;
      div_shift  = {div_rem, div_q[31]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= '0;
         sync2  <= '0;
         code_q <= '0;
         fcnt   <= '0;
      end else begin
         sync1 <= {bus.hall_c, bus.hall_b, bus.hall_a};
         sync2 <= sync1;
         if (sync2 != code_q) begin
            code_q <= sync2;
            fcnt   <= FW'(1);
         end else if (fcnt != FW'(FILT_LEN)) begin
            fcnt <= fcnt + FW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_r    <= '0;
         base      <= '0;
         pos       <= '0;
         step      <= '0;
         valid_r   <= 1'b0;
         edge_r    <= 1'b0;
         err_r     <= 1'b0;
         dir_r     <= 1'b0;
         stall_r   <= 1'b0;
         period_ok <= 1'b0;
         pcnt      <= '0;
         period_r  <= '0;
         div_st    <= D_IDLE;
         div_cnt   <= '0;
         div_q     <= '0;
         div_rem   <= '0;
         div_d     <= '0;
      end else begin
         edge_r <= 1'b0;
         err_r  <= 1'b0;

         case (div_st)
            D_RUN: begin
               if (div_shift >= {1'b0, div_d}) begin
                  div_rem <= 24'(div_shift - {1'b0, div_d});
                  div_q   <= {div_q[30:0], 1'b1};
               end else begin
                  div_rem <= div_shift[23:0];
                  div_q   <= {div_q[30:0], 1'b0};
               end
               div_cnt <= div_cnt + 5'd1;
               if (div_cnt == 5'd31) div_st <= D_LOAD;
            end
            D_LOAD: begin
               step   <= div_q;
               div_st <= D_IDLE;
            end
            default: ;
         endcase

         if (valid_r && !stall_r) begin
            pos  <= dir_r ? pos_fwd : pos_rev;
            pcnt <= pcnt_inc;
            // An edge in the same cycle wins over the stall.
            if (pcnt_inc == PERIOD_MAX && !accept) begin
               stall_r   <= 1'b1;
               step      <= '0;
               period_ok <= 1'b0;
               div_st    <= D_IDLE;
            end
         end

         if (stable_hit && is_inv) err_r <= 1'b1;

         if (accept) begin
            code_r  <= sync2;
            base    <= 22'd300000 + 22'(new_idx) * 22'd600000;
            pcnt    <= '0;
            stall_r <= 1'b0;
            if (!valid_r) begin
               valid_r   <= 1'b1;
               pos       <= POS_MID;
               step      <= '0;
               period_ok <= 1'b0;
            end else begin
               edge_r <= 1'b1;
               if (fwd || rev) begin
                  dir_r <= fwd;
                  pos   <= fwd ? '0 : POS_MAX[PW-1:0];
                  if (period_ok) begin
                     period_r <= pcnt_inc;
                     div_st   <= D_RUN;
                     div_cnt  <= '0;
                     div_q    <= DIVIDEND;
                     div_rem  <= '0;
                     div_d    <= pcnt_inc;
                  end else begin
                     period_ok <= 1'b1;
                  end
               end else begin
                  err_r     <= 1'b1;
                  pos       <= POS_MID;
                  step      <= '0;
                  period_ok <= 1'b0;
                  div_st    <= D_IDLE;
               end
            end
         end
      end
   end

   assign bus.hall_code  = {29'd0, code_r};
   assign bus.hall_angle = {9'd0, angle_mod};
   assign bus.hall_valid = valid_r;
   assign bus.edge_pulse = edge_r;
   assign bus.hall_err   = err_r;
   assign bus.dir        = dir_r;
   assign bus.period     = period_r;
   assign bus.stall      = stall_r;
endmodule
